// File: rtl/aes_enc_ctrl.sv
// AES-128 encryption round sequencer: runs the initial key-add round and rounds 1..NR,
// stalling on round-key availability, then holds the ciphertext until it is consumed.
module aes_enc_ctrl #(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 3
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_valid_i,
    output logic       start_ready_o,
    input  logic       rnd_key_valid_i,
    output logic [3:0] rnd_idx_o,
    output logic       en_o,
    output logic       full_enc_o,
    output logic       zero_rnd_o,
    output logic       final_rnd_o,
    output logic       cipher_valid_o,
    input  logic       cipher_ready_i,
    output logic       busy_o
);
    localparam int CW = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(ROUND_LAT - 1);
    localparam logic [3:0]    RND_LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE, ROUND0, ROUND, DONE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          adv;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rnd_d          = rnd_q;
        cyc_d          = cyc_q;
        adv            = 1'b0;
        start_ready_o  = 1'b0;
        busy_o         = 1'b0;
        en_o           = 1'b0;
        full_enc_o     = 1'b0;
        zero_rnd_o     = 1'b0;
        final_rnd_o    = 1'b0;
        cipher_valid_o = 1'b0;
        rnd_idx_o      = 4'd0;
        case (state_q)
            IDLE: begin
                start_ready_o = 1'b1;
                if (start_valid_i) begin
                    state_d = ROUND0;
                    rnd_d   = 4'd0;
                    cyc_d   = '0;
                end
            end
            ROUND0: begin
                busy_o     = 1'b1;
                en_o       = 1'b1;
                full_enc_o = 1'b1;
                zero_rnd_o = 1'b1;
                state_d    = ROUND;
                rnd_d      = 4'd1;
                cyc_d      = '0;
            end
            ROUND: begin
                busy_o      = 1'b1;
                rnd_idx_o   = rnd_q;
                final_rnd_o = (rnd_q == RND_LAST);
                // The key is only needed to launch a round; later cycles run regardless.
                adv         = (cyc_q != '0) || rnd_key_valid_i;
                en_o        = adv;
                if (adv) begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_d = '0;
                        if (rnd_q == RND_LAST) begin
                            state_d = DONE;
                            rnd_d   = 4'd0;
                        end else begin
                            rnd_d = rnd_q + 4'd1;
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            DONE: begin
                busy_o         = 1'b1;
                cipher_valid_o = 1'b1;
                if (cipher_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
